// File: rtl/fmdll_pkg.sv
// Shared types and default sizing for the DLL delay-code controller.
package fmdll_pkg;

  localparam int CODE_W_DEF     = 6;
  localparam int SETTLE_DEF     = 2;
  localparam int LOCK_CNT_DEF   = 8;
  localparam int UNLOCK_CNT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SAR   = 2'd1,
    TRACK = 2'd2
  } dll_state_e;

  // Bits needed to hold the value n (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dll_settle_timer.sv
// Settle timer: waits SETTLE cycles after each code change so the delay
// line and phase detector can settle; expired marks the decision cycle.
module dll_settle_timer
  import fmdll_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  output logic expired
);

  localparam int CW = cnt_w(SETTLE);

  logic [CW-1:0] r_cnt;

  // Clear wins over load; otherwise count down to zero and stay there.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)             r_cnt <= '0;
    else if (clear)         r_cnt <= '0;
    else if (load)          r_cnt <= CW'(SETTLE);
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign expired = (r_cnt == '0);

endmodule

// File: rtl/dll_delay_ctrl.sv
// DLL delay-code controller: binary-search acquisition of the delay code,
// then +/-1 tracking with lock detection from decision alternation.
module dll_delay_ctrl
  import fmdll_pkg::*;
#(
  parameter int CODE_W     = CODE_W_DEF,
  parameter int SETTLE     = SETTLE_DEF,
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int UNLOCK_CNT = UNLOCK_CNT_DEF
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              start,
  input  logic              up_dn,
  output logic [CODE_W-1:0] code,
  output logic              busy,
  output logic              locked
);

  localparam int BI_W = cnt_w(CODE_W - 1);
  localparam int LC_W = cnt_w(LOCK_CNT);
  localparam int UC_W = cnt_w(UNLOCK_CNT);
  localparam logic [CODE_W-1:0] CODE_ONE = CODE_W'(1);
  localparam logic [CODE_W-1:0] CODE_MSB = CODE_ONE << (CODE_W - 1);
  localparam logic [BI_W-1:0]   BIT_TOP  = BI_W'(CODE_W - 1);

  dll_state_e        r_state, w_state_nxt;
  logic [CODE_W-1:0] r_code;
  logic [BI_W-1:0]   r_bit;
  logic [LC_W-1:0]   r_alt, w_alt_nxt;
  logic [UC_W-1:0]   r_run, w_run_nxt;
  logic              r_locked;
  logic              r_prev_dir;
  logic              r_have_prev;

  logic              w_expired;
  logic              w_load;
  logic [CODE_W-1:0] w_cur_mask;
  logic [CODE_W-1:0] w_sar_code;

  // Reload on entering acquisition and after every decision (code may change).
  assign w_load = start && ((r_state == IDLE) || w_expired);

  dll_settle_timer #(.SETTLE(SETTLE)) u_settle (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .load    (w_load),
    .clear   (!start),
    .expired (w_expired)
  );

  // SAR trial: keep or drop the bit under test, then raise the next lower one.
  assign w_cur_mask = CODE_ONE << r_bit;
  assign w_sar_code = (up_dn ? r_code : (r_code & ~w_cur_mask)) | (w_cur_mask >> 1);

  // Next state plus alternation/run counter updates for a tracking decision.
  always_comb begin
    w_state_nxt = r_state;
    w_alt_nxt   = r_alt;
    w_run_nxt   = r_run;
    if (!start) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = SAR;
        SAR:     if (w_expired && (r_bit == '0)) w_state_nxt = TRACK;
        TRACK:   w_state_nxt = TRACK;
        default: w_state_nxt = IDLE;
      endcase
    end
    if (!r_have_prev) begin
      // First tracking decision has no predecessor to alternate against.
      w_alt_nxt = '0;
      w_run_nxt = UC_W'(1);
    end else if (up_dn != r_prev_dir) begin
      w_run_nxt = UC_W'(1);
      if (r_alt != LC_W'(LOCK_CNT)) w_alt_nxt = r_alt + 1'b1;
    end else begin
      w_alt_nxt = LC_W'(1);
      if (r_run != UC_W'(UNLOCK_CNT)) w_run_nxt = r_run + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Code, bit index, decision history and lock flag.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_code      <= '0;
      r_bit       <= BIT_TOP;
      r_alt       <= '0;
      r_run       <= '0;
      r_locked    <= 1'b0;
      r_prev_dir  <= 1'b0;
      r_have_prev <= 1'b0;
    end else if (!start) begin
      // Code is held so the delay line keeps its last setting while idle.
      r_bit       <= BIT_TOP;
      r_alt       <= '0;
      r_run       <= '0;
      r_locked    <= 1'b0;
      r_prev_dir  <= 1'b0;
      r_have_prev <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_code <= CODE_MSB;
          r_bit  <= BIT_TOP;
        end
        SAR: if (w_expired) begin
          r_code <= w_sar_code;
          if (r_bit != '0) r_bit <= r_bit - 1'b1;
        end
        TRACK: if (w_expired) begin
          if (up_dn) begin
            if (r_code != '1) r_code <= r_code + 1'b1;
          end else begin
            if (r_code != '0) r_code <= r_code - 1'b1;
          end
          r_alt       <= w_alt_nxt;
          r_run       <= w_run_nxt;
          r_prev_dir  <= up_dn;
          r_have_prev <= 1'b1;
          if (w_run_nxt == UC_W'(UNLOCK_CNT))     r_locked <= 1'b0;
          else if (w_alt_nxt == LC_W'(LOCK_CNT))  r_locked <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign code   = r_code;
  assign busy   = (r_state == SAR);
  assign locked = r_locked;

endmodule

// File: tb/tb_dll_delay_ctrl.sv
// Bench for dll_delay_ctrl: integer behavioural model checked every cycle,
// plus directed literal checks of the acquisition/tracking sequences.
module tb_dll_delay_ctrl;

  localparam int W    = 6;
  localparam int ST   = 2;
  localparam int LCK  = 8;
  localparam int UNL  = 4;
  localparam int CMAX = (1 << W) - 1;

  logic         clk_in = 1'b0;
  logic         rst_n  = 1'b1;
  logic         start  = 1'b0;
  logic         up_dn  = 1'b0;
  logic [W-1:0] code;
  logic         busy;
  logic         locked;

  int total = 0;
  int bad   = 0;
  int pd_mode = 0;     // 0: up_dn=(code<37), 1: always up
  bit chk_en  = 1'b0;
  int k;
  int busy_cnt;
  int sar_seq [6] = '{32, 48, 40, 36, 38, 37};

  dll_delay_ctrl #(.CODE_W(W), .SETTLE(ST), .LOCK_CNT(LCK), .UNLOCK_CNT(UNL)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .start  (start),
    .up_dn  (up_dn),
    .code   (code),
    .busy   (busy),
    .locked (locked)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Phase-detector stand-in, updated away from the sampling edge.
  always @(negedge clk_in)
    up_dn = (pd_mode == 0) ? (code < 37) : 1'b1;

  // Behavioural model: mode 0 idle, 1 search, 2 track; wait = cycles to decision.
  int m_mode = 0, m_code = 0, m_bit = W - 1, m_wait = 0;
  int m_alt = 0, m_run = 0, m_lock = 0, m_have = 0, m_prev = 0;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_code = 0; m_bit = W - 1; m_wait = 0;
      m_alt = 0; m_run = 0; m_lock = 0; m_have = 0; m_prev = 0;
    end else if (!start) begin
      m_mode = 0; m_bit = W - 1; m_wait = 0;
      m_alt = 0; m_run = 0; m_lock = 0; m_have = 0; m_prev = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_code = 1 << (W - 1); m_bit = W - 1; m_wait = ST;
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (m_mode == 1) begin
      if (!up_dn) m_code -= (1 << m_bit);
      if (m_bit > 0) begin
        m_bit--;
        m_code += (1 << m_bit);
      end else begin
        m_mode = 2;
      end
      m_wait = ST;
    end else begin
      if (up_dn) m_code = (m_code < CMAX) ? m_code + 1 : CMAX;
      else       m_code = (m_code > 0) ? m_code - 1 : 0;
      if (!m_have) begin
        m_alt = 0; m_run = 1;
      end else if (int'(up_dn) != m_prev) begin
        m_alt = (m_alt < LCK) ? m_alt + 1 : LCK;
        m_run = 1;
      end else begin
        m_alt = 1;
        m_run = (m_run < UNL) ? m_run + 1 : UNL;
      end
      if (m_run == UNL)      m_lock = 0;
      else if (m_alt == LCK) m_lock = 1;
      m_have = 1;
      m_prev = int'(up_dn);
      m_wait = ST;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("mdl_code", int'(code), m_code);
      chk("mdl_busy", int'(busy), int'(m_mode == 1));
      chk("mdl_lock", int'(locked), m_lock);
    end
  end

  task automatic tick();
    @(negedge clk_in);
    k++;
  endtask

  initial begin
    start = 1'b1;
    pd_mode = 0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("rst_code", int'(code), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_lock", int'(locked), 0);
    rst_n = 1'b1;

    // Acquisition then tracking with the code<37 detector, then forced up.
    k = -1;
    busy_cnt = 0;
    for (int i = 0; i <= 54; i++) begin
      tick();
      if (k <= 20) busy_cnt += int'(busy);
      if (k < 18 && (k % 3) == 0) chk("sar_seq", int'(code), sar_seq[k / 3]);
      case (k)
        18: begin chk("sar_final", int'(code), 36); chk("sar_busy_off", int'(busy), 0); end
        20: chk("busy_cycles", busy_cnt, 18);
        21: chk("trk_up", int'(code), 37);
        24: chk("trk_dn", int'(code), 36);
        44: chk("pre_lock", int'(locked), 0);
        45: begin chk("lock_rise", int'(locked), 1); chk("lock_code", int'(code), 37); end
        46: pd_mode = 1;
        48: chk("climb1", int'(code), 38);
        51: begin chk("climb2", int'(code), 39); chk("still_lock", int'(locked), 1); end
        53: chk("lock_hold", int'(locked), 1);
        54: begin chk("climb3", int'(code), 40); chk("unlock", int'(locked), 0); end
        default: ;
      endcase
    end

    // Stop: code held in idle. Then all-up search saturates at the top code.
    start = 1'b0;
    tick();
    chk("idle_hold", int'(code), 40);
    chk("idle_busy", int'(busy), 0);
    start = 1'b1;
    k = -1;
    for (int i = 0; i <= 30; i++) begin
      tick();
      case (k)
        0:  chk("sat_start", int'(code), 32);
        18: begin chk("sat_sar", int'(code), 63); chk("sat_busy", int'(busy), 0); end
        30: begin chk("sat_trk", int'(code), 63); chk("sat_nolock", int'(locked), 0); end
        default: ;
      endcase
    end

    // Abort acquisition partway, then restart it.
    start = 1'b0;
    tick();
    pd_mode = 0;
    start = 1'b1;
    k = -1;
    for (int i = 0; i <= 8; i++) begin
      tick();
      case (k)
        0: chk("ab_start", int'(code), 32);
        6: begin chk("ab_mid", int'(code), 40); start = 1'b0; end
        7: begin
          chk("ab_hold", int'(code), 40);
          chk("ab_busy", int'(busy), 0);
          start = 1'b1;
        end
        8: begin chk("ab_restart", int'(code), 32); chk("ab_rbusy", int'(busy), 1); end
        default: ;
      endcase
    end

    // Reset in the middle of tracking aborts immediately; idle until start.
    repeat (30) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_code", int'(code), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_lock", int'(locked), 0);
    start = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_idle_busy", int'(busy), 0);
    chk("post_idle_code", int'(code), 0);
    start = 1'b1;
    tick();
    chk("post_start", int'(code), 32);
    chk("post_busy", int'(busy), 1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
